// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI types and constants for the mode-0 master/slave pair
package spi_pkg;
   typedef enum logic {IDLE, SHIFT} state_e;
   localparam int   DEF_DATA_W      = 8;
   localparam int   DEF_SYNC_STAGES = 2;
   localparam logic SPI_CPOL        = 1'b0;
   localparam logic SPI_CPHA        = 1'b0;
   localparam logic CSN_IDLE        = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser with registered rise/fall strobes
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync_q, sync_d;
   logic prev_q, rise_q, rise_d, fall_q, fall_d;
   assign q    = sync_q[STAGES-1];
   assign rise = rise_q;
   assign fall = fall_q;
   // shift the pin through the chain and compare the output with its previous value
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      rise_d = q & ~prev_q;
      fall_d = ~q & prev_q;
   end
   // synchroniser, history and strobe registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= q;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder with one-entry tx holding register (optional frame_err via SPI_SLAVE_FRAME_ERR_EN)
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
`ifdef SPI_SLAVE_FRAME_ERR_EN
   output logic              frame_err,
`endif
   input  logic              spi_sck,
   input  logic              spi_csn,
   input  logic              spi_mosi,
   output logic              spi_miso
);
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W-1);
   logic sck_unused, sck_rise, sck_fall, csn_s, csn_rise, csn_fall, mosi_s, sample, shift, load;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   state_e state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, hold_q, hold_d, word;
   logic rx_valid_q, rx_valid_d, miso_q, miso_d, word_done_q, word_done_d, hold_full_q, hold_full_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic frame_err_q, frame_err_d;
   assign frame_err = frame_err_q;
`endif
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sck (
      .clk(clk), .reset_n(reset_n), .d(spi_sck), .q(sck_unused), .rise(sck_rise), .fall(sck_fall));
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CSN_IDLE)) u_csn (
      .clk(clk), .reset_n(reset_n), .d(spi_csn), .q(csn_s), .rise(csn_rise), .fall(csn_fall));
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sample   = (SPI_CPOL ^ SPI_CPHA) ? sck_fall : sck_rise;
   assign shift    = (SPI_CPOL ^ SPI_CPHA) ? sck_rise : sck_fall;
   assign word     = hold_full_q ? hold_q : (tx_valid ? tx_data : '0);
   assign tx_ready = ~hold_full_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = ~csn_s;
   assign spi_miso = miso_q;
   // next-state: frame control, bit sampling/shifting and holding-register bookkeeping
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      miso_d      = miso_q;
      word_done_d = word_done_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      load        = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = 1'b0;
`endif
      if (state_q == IDLE) begin
         if (csn_fall) begin
            state_d     = SHIFT;
            load        = 1'b1;
            bit_cnt_d   = CNT_MAX;
            word_done_d = 1'b0;
         end
      end else if (csn_rise) begin
         state_d     = IDLE;
         bit_cnt_d   = CNT_MAX;
         miso_d      = 1'b0;
         word_done_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_d = bit_cnt_q != CNT_MAX;
`endif
      end else begin
         if (sample) begin
            rx_shift_d[bit_cnt_q] = mosi_s;
            if (bit_cnt_q == '0) begin
               rx_data_d   = {rx_shift_q[DATA_W-1:1], mosi_s};
               rx_valid_d  = 1'b1;
               bit_cnt_d   = CNT_MAX;
               word_done_d = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q - 1'b1;
            end
         end
         if (shift) begin
            if (word_done_q) begin
               load        = 1'b1;
               word_done_d = 1'b0;
            end else begin
               tx_shift_d = tx_shift_q << 1;
               miso_d     = tx_shift_q[DATA_W-2];
            end
         end
      end
      if (load) begin
         tx_shift_d  = word;
         miso_d      = word[DATA_W-1];
         hold_full_d = 1'b0;
      end else if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_d = frame_err_d | (load && !hold_full_q && !tx_valid);
`endif
   end
   // state and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mosi_sync_q <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= CNT_MAX;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b0;
         word_done_q <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= 1'b0;
`endif
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
         word_done_q <= word_done_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_err_q <= frame_err_d;
`endif
      end
   end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) responder, MSB first; pairs with the team's SPI master on the same four-wire bus.
- Oversamples SCK/CSN/MOSI in the system clock domain through synchronisers and detects edges.
- Presents received words on a one-cycle-pulse output.
- Supplies transmit words from a one-entry holding register loaded with a valid/ready handshake.

Parameters:
DATA_W, 8, word length in bits per transfer
SYNC_STAGES, 2, flip-flop depth of the SCK/CSN/MOSI input synchronisers (minimum 2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
tx_data  input  DATA_W  next word to shift out on MISO
tx_valid  input  1  tx_data valid; accepted in a cycle where tx_valid && tx_ready
tx_ready  output  1  holding register empty
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  one-clk pulse: rx_data updated
busy  output  1  CSN (synchronised) low
spi_sck  input  1  bus clock from master; frequency must be at most clk/8
spi_csn  input  1  chip select, active low
spi_mosi  input  1  master-out data
spi_miso  output  1  slave-out data; driven 0 while deselected, no tristate

Behaviour:
- Reset values (reset_n low, asynchronous):
  - rx_data=0, rx_valid=0, tx_ready=1, busy=0, spi_miso=0.
  - Synchronisers load SCK=0 and CSN=1.
  - Holding register empty; bit counter = DATA_W-1.
- Edge detection:
  - Synchronised SCK and CSN are compared with their previous-cycle values.
  - Edge strobes are available SYNC_STAGES+1 clk after the pin edge.
- State machine has two states, IDLE and SHIFT.
- IDLE to SHIFT on a CSN falling strobe:
  - Shift register loads the holding register, or 0 if the holding register is empty.
  - spi_miso = MSB on the next clk. The master must allow at least SYNC_STAGES+3 clk from CSN low to the first SCK rise.
  - bit_cnt = DATA_W-1.
- SHIFT, SCK rising strobe:
  - Sample synchronised MOSI into rx_shift[bit_cnt].
  - If bit_cnt==0: rx_data <= completed word, rx_valid pulses high for exactly 1 clk on the following cycle, bit_cnt <= DATA_W-1, and a "word done" flag is set.
  - Otherwise bit_cnt decrements.
- SHIFT, SCK falling strobe:
  - If word done: reload the shift register from the holding register (0 if empty), drive the MSB, and clear word done. This supports back-to-back burst words while CSN stays low.
  - Otherwise spi_miso <= next lower bit.
- SHIFT to IDLE on a CSN rising strobe:
  - A partial word is discarded and rx_data is unchanged.
  - bit_cnt resets; spi_miso <= 0.
  - Holding register content is retained.
- Holding register:
  - tx_ready is high while the register is empty; a handshake writes it.
  - It is emptied when its content is loaded into the shift register.
  - Simultaneous load and handshake in the same clk while empty: tx_data bypasses directly into the shift register and counts as accepted; the holding register stays empty.
  - Handshake while full is impossible because tx_ready=0.
- busy mirrors the synchronised CSN inverted.
- SCK edges seen while CSN is high are ignored.
- reset_n asserted mid-transfer aborts immediately to reset values.

Optional Feature:
- Macro SPI_SLAVE_FRAME_ERR_EN.
- Defined:
  - Adds output frame_err (1 bit, reset 0).
  - frame_err pulses for 1 clk when a CSN rising strobe occurs with a partial word in progress (bit_cnt != DATA_W-1 and at least one rising edge sampled).
  - Also pulses if a word starts with the holding register empty (underrun).
- Undefined: port absent; these conditions are silently tolerated as described above.

Decomposition:
- Shared package spi_pkg: state enum (IDLE, SHIFT), default DATA_W and SYNC_STAGES constants, and the SPI mode-0 polarity constants shared with the master.
- One natural sub-module, spi_sync_edge: an N-stage synchroniser with rise/fall strobe outputs, instantiated for SCK and CSN. MOSI uses only the synchroniser path.

Test Plan:
- Reset, then CSN low, then master sends 0xA5 at clk/8 with holding register = 0x3C → rx_valid pulses once, rx_data=0xA5, MISO bitstream 0x3C, tx_ready returns high after the load.
- Burst of 3 words 0x01,0x80,0xFF in one CSN window, tx words 0x11,0x22 written via handshake before each boundary → rx_valid pulses 3 times with values in order. MISO shows 0x11, 0x22, then 0x00 on the empty holding register.
- CSN raised after 5 SCK rises → no rx_valid, rx_data unchanged, next frame receives 0x5A correctly. With SPI_SLAVE_FRAME_ERR_EN, frame_err pulses once.
- tx_valid asserted in the exact clk of the word-boundary load while the register is empty, tx_data=0xC3 → MISO sends 0xC3 and tx_ready stays high.
- reset_n low midway through a word → all outputs at reset values within the same clk; next full frame 0x96 is received correctly.
- SCK toggling with CSN high → no rx_valid, MISO held 0, busy=0.
